// File: rtl/axi_demux_b_resp_pkg.sv
// Shared definitions for the B-channel return path of the slave-side demux.
// Provides the index-width helper used to size master-port selects and the
// AXI BRESP encoding.
package axi_demux_b_resp_pkg;

  // Number of bits needed to index n items; never less than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

  // AXI write-response encoding.
  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

endpackage

// File: rtl/axi_rr_arbiter.sv
// Round-robin arbiter over a valid vector.
// Ports:
//   clk_i, rst_ni  clock and async active-low reset
//   valid_i        per-requester valid
//   advance_i      grant was consumed this cycle; move the pointer to it
//   grant_o        index of the winning requester (0 when nothing is valid)
//   any_valid_o    at least one requester is valid
// The pointer resets to the last index so requester 0 wins first.
module axi_rr_arbiter
  import axi_demux_b_resp_pkg::*;
#(
  parameter int unsigned NoMstPorts = 4,
  parameter type select_t = logic [idx_width(NoMstPorts)-1:0]
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NoMstPorts-1:0] valid_i,
  input  logic                  advance_i,
  output select_t               grant_o,
  output logic                  any_valid_o
);

  select_t rr_q, rr_d;
  select_t grant_hi_s, grant_lo_s;
  logic    hi_found_s, lo_found_s;

  // Priority search: lowest valid index above the pointer wins; otherwise the
  // lowest valid index overall (wrap-around, pointer position last). Only
  // legal indices are visited, so unused codes of a non-power-of-two count
  // are skipped.
  always_comb begin
    grant_hi_s = '0;
    grant_lo_s = '0;
    hi_found_s = 1'b0;
    lo_found_s = 1'b0;
    for (int i = int'(NoMstPorts) - 1; i >= 0; i--) begin
      if (valid_i[i]) begin
        grant_lo_s = select_t'(i);
        lo_found_s = 1'b1;
        if (select_t'(i) > rr_q) begin
          grant_hi_s = select_t'(i);
          hi_found_s = 1'b1;
        end else begin
          hi_found_s = hi_found_s;
        end
      end else begin
        lo_found_s = lo_found_s;
      end
    end
  end

  // Grant selection and pointer next state.
  always_comb begin
    grant_o     = hi_found_s ? grant_hi_s : grant_lo_s;
    any_valid_o = lo_found_s;
    if (advance_i && lo_found_s) begin
      rr_d = grant_o;
    end else begin
      rr_d = rr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= select_t'(NoMstPorts - 32'd1);
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/axi_demux_b_resp.sv
// B-channel return path of the slave-side demux. Arbitrates the master-side
// B channels round-robin into a one-entry output register driving the single
// slave-port B channel, pops the write-ID tracking array on every slave
// handshake and flags responses that do not match the tracking array.
// Ports:
//   clk_i, rst_ni                 clock and async active-low reset
//   mst_b_valid_i/ready_o/id_i/resp_i   per-master-port B channels
//   slv_b_valid_o/ready_i/id_o/resp_o   slave-port B channel
//   lookup_axi_id_o               ID LSBs of the current winner
//   lookup_sel_i, lookup_sel_occupied_i  tracking-array answer for that ID
//   pop_en_o, pop_axi_id_o        pop one in-flight entry
//   err_o                         one-cycle pulse: unexpected response accepted
module axi_demux_b_resp
  import axi_demux_b_resp_pkg::*;
#(
  parameter int unsigned NoMstPorts  = 4,
  parameter int unsigned IdWidth     = 4,
  parameter int unsigned AxiLookBits = 3,
  parameter type select_t = logic [idx_width(NoMstPorts)-1:0]
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NoMstPorts-1:0]               mst_b_valid_i,
  output logic [NoMstPorts-1:0]               mst_b_ready_o,
  input  logic [NoMstPorts-1:0][IdWidth-1:0]  mst_b_id_i,
  input  logic [NoMstPorts-1:0][1:0]          mst_b_resp_i,
  output logic                                slv_b_valid_o,
  input  logic                                slv_b_ready_i,
  output logic [IdWidth-1:0]                  slv_b_id_o,
  output logic [1:0]                          slv_b_resp_o,
  output logic [AxiLookBits-1:0]              lookup_axi_id_o,
  input  select_t                             lookup_sel_i,
  input  logic                                lookup_sel_occupied_i,
  output logic                                pop_en_o,
  output logic [AxiLookBits-1:0]              pop_axi_id_o,
  output logic                                err_o
);

  logic               valid_q, valid_d;
  logic [IdWidth-1:0] id_q, id_d;
  resp_t              resp_q, resp_d;
  logic               err_q, err_d;

  logic    load_s;
  logic    any_valid_s;
  logic    accept_s;
  select_t grant_s;

  // The output register can take a new response when empty or draining.
  assign load_s   = ~valid_q | slv_b_ready_i;
  assign accept_s = load_s & any_valid_s;

  axi_rr_arbiter #(
    .NoMstPorts (NoMstPorts),
    .select_t   (select_t)
  ) i_arb (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .valid_i     (mst_b_valid_i),
    .advance_i   (load_s),
    .grant_o     (grant_s),
    .any_valid_o (any_valid_s)
  );

  // Only the winner sees ready, so ready never depends on a losing valid.
  always_comb begin
    mst_b_ready_o = '0;
    if (any_valid_s) begin
      mst_b_ready_o[grant_s] = load_s;
    end else begin
      mst_b_ready_o = '0;
    end
  end

  // Tracking-array lookup for the current winner.
  always_comb begin
    if (any_valid_s) begin
      lookup_axi_id_o = mst_b_id_i[grant_s][AxiLookBits-1:0];
    end else begin
      lookup_axi_id_o = '0;
    end
  end

  // Output register next state; erroneous responses are still forwarded.
  always_comb begin
    valid_d = valid_q;
    id_d    = id_q;
    resp_d  = resp_q;
    err_d   = 1'b0;
    if (accept_s) begin
      valid_d = 1'b1;
      id_d    = mst_b_id_i[grant_s];
      resp_d  = resp_t'(mst_b_resp_i[grant_s]);
      err_d   = ~lookup_sel_occupied_i | (lookup_sel_i != grant_s);
    end else if (load_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Output register and error pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      id_q    <= '0;
      resp_q  <= RESP_OKAY;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      id_q    <= id_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
    end
  end

  assign slv_b_valid_o = valid_q;
  assign slv_b_id_o    = id_q;
  assign slv_b_resp_o  = resp_q;
  assign err_o         = err_q;

  // One pop per completed slave-port handshake.
  assign pop_en_o     = valid_q & slv_b_ready_i;
  assign pop_axi_id_o = id_q[AxiLookBits-1:0];

endmodule

// File: tb/tb_axi_demux_b_resp.sv
module tb_axi_demux_b_resp;

  logic            clk;
  logic            rst_ni;
  logic [3:0]      mst_b_valid;
  logic [3:0]      mst_b_ready;
  logic [3:0][3:0] mst_b_id;
  logic [3:0][1:0] mst_b_resp;
  logic            slv_b_valid;
  logic            slv_b_ready;
  logic [3:0]      slv_b_id;
  logic [1:0]      slv_b_resp;
  logic [2:0]      lookup_axi_id;
  logic [1:0]      lookup_sel;
  logic            lookup_occ;
  logic            pop_en;
  logic [2:0]      pop_axi_id;
  logic            err;

  // Tracking-array model answering the lookup.
  logic [1:0] sel_tbl [8];
  logic       occ_tbl [8];
  assign lookup_sel = sel_tbl[lookup_axi_id];
  assign lookup_occ = occ_tbl[lookup_axi_id];

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int err_cnt = 0;
  logic [5:0] exp_q [$];

  axi_demux_b_resp dut (
    .clk_i                 (clk),
    .rst_ni                (rst_ni),
    .mst_b_valid_i         (mst_b_valid),
    .mst_b_ready_o         (mst_b_ready),
    .mst_b_id_i            (mst_b_id),
    .mst_b_resp_i          (mst_b_resp),
    .slv_b_valid_o         (slv_b_valid),
    .slv_b_ready_i         (slv_b_ready),
    .slv_b_id_o            (slv_b_id),
    .slv_b_resp_o          (slv_b_resp),
    .lookup_axi_id_o       (lookup_axi_id),
    .lookup_sel_i          (lookup_sel),
    .lookup_sel_occupied_i (lookup_occ),
    .pop_en_o              (pop_en),
    .pop_axi_id_o          (pop_axi_id),
    .err_o                 (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int p, input logic [3:0] id, input logic [1:0] resp);
    mst_b_valid[p] = 1'b1;
    mst_b_id[p]    = id;
    mst_b_resp[p]  = resp;
  endtask

  task automatic set_tbl(input int idx, input logic [1:0] sel, input logic occ);
    sel_tbl[idx] = sel;
    occ_tbl[idx] = occ;
  endtask

  // Scoreboard: every slave handshake pops one expected response.
  always @(negedge clk) begin
    if (rst_ni === 1'b1) begin
      if (slv_b_valid === 1'b1 && slv_b_ready === 1'b1) begin
        pops++;
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL sb_empty: observed response id %0h expected none", slv_b_id);
        end
        if (exp_q.size() != 0) begin
          logic [5:0] e;
          e = exp_q.pop_front();
          chk("sb_id", 32'(slv_b_id), 32'(e[5:2]));
          chk("sb_resp", 32'(slv_b_resp), 32'(e[1:0]));
          chk("sb_pop_en", 32'(pop_en), 32'd1);
          chk("sb_pop_id", 32'(pop_axi_id), 32'(e[4:2]));
        end
      end else begin
        chk("pop_idle", 32'(pop_en), 32'd0);
      end
      if (err === 1'b1) err_cnt++;
    end
  end

  initial begin
    int p0;
    int e0;
    rst_ni      = 1'b1;
    mst_b_valid = '0;
    mst_b_id    = '0;
    mst_b_resp  = '0;
    slv_b_ready = 1'b0;
    for (int i = 0; i < 8; i++) set_tbl(i, 2'd0, 1'b0);
    #2 rst_ni = 1'b0;
    cyc();
    cyc();
    // Reset state
    chk("rst_slv_valid", 32'(slv_b_valid), 32'd0);
    chk("rst_pop_en", 32'(pop_en), 32'd0);
    chk("rst_ready", 32'(mst_b_ready), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_ni = 1'b1;

    // Fairness: all ports valid, ready held high
    for (int i = 0; i < 4; i++) begin
      set_tbl(i, 2'(i), 1'b1);
      send(i, 4'(i + 8), 2'(i));
    end
    slv_b_ready = 1'b1;
    p0 = pops;
    e0 = err_cnt;
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back({4'((k % 4) + 8), 2'(k % 4)});
      #2;
      chk("fair_grant", 32'(mst_b_ready), 32'(4'b0001 << (k % 4)));
      cyc();
    end
    mst_b_valid = '0;
    cyc();
    chk("fair_pops", 32'(pops - p0), 32'd8);
    chk("fair_err", 32'(err_cnt - e0), 32'd0);

    // Single response from port 2
    set_tbl(5, 2'd2, 1'b1);
    send(2, 4'h5, 2'b00);
    exp_q.push_back({4'h5, 2'b00});
    #2;
    chk("single_ready", 32'(mst_b_ready), 32'b0100);
    chk("single_lookup", 32'(lookup_axi_id), 32'd5);
    cyc();
    mst_b_valid = '0;
    #2;
    chk("single_valid", 32'(slv_b_valid), 32'd1);
    chk("single_id", 32'(slv_b_id), 32'h5);
    chk("single_pop_en", 32'(pop_en), 32'd1);
    chk("single_pop_id", 32'(pop_axi_id), 32'd5);
    chk("single_err", 32'(err), 32'd0);
    cyc();
    #2;
    chk("single_done", 32'(slv_b_valid), 32'd0);
    cyc();

    // Back-pressure: one response parked, ports 1 and 3 waiting
    set_tbl(2, 2'd0, 1'b1);
    set_tbl(6, 2'd1, 1'b1);
    set_tbl(4, 2'd3, 1'b1);
    slv_b_ready = 1'b0;
    send(0, 4'h2, 2'b10);
    exp_q.push_back({4'h2, 2'b10});
    #2;
    chk("bp_first_ready", 32'(mst_b_ready), 32'b0001);
    cyc();
    mst_b_valid[0] = 1'b0;
    send(1, 4'h6, 2'b01);
    send(3, 4'hC, 2'b11);
    exp_q.push_back({4'h6, 2'b01});
    exp_q.push_back({4'hC, 2'b11});
    for (int k = 0; k < 5; k++) begin
      #2;
      chk("bp_ready", 32'(mst_b_ready), 32'd0);
      chk("bp_valid", 32'(slv_b_valid), 32'd1);
      chk("bp_id", 32'(slv_b_id), 32'h2);
      chk("bp_resp", 32'(slv_b_resp), 32'b10);
      cyc();
    end
    slv_b_ready = 1'b1;
    #2;
    chk("bp_rel_port1", 32'(mst_b_ready), 32'b0010);
    cyc();
    mst_b_valid[1] = 1'b0;
    #2;
    chk("bp_rel_port3", 32'(mst_b_ready), 32'b1000);
    chk("bp_id1", 32'(slv_b_id), 32'h6);
    cyc();
    mst_b_valid[3] = 1'b0;
    #2;
    chk("bp_id3", 32'(slv_b_id), 32'hC);
    cyc();
    cyc();

    // Mismatch: port 0 returns ID 3 recorded for port 1
    set_tbl(3, 2'd1, 1'b1);
    e0 = err_cnt;
    send(0, 4'h3, 2'b00);
    exp_q.push_back({4'h3, 2'b00});
    #2;
    chk("mm_lookup", 32'(lookup_axi_id), 32'd3);
    chk("mm_ready", 32'(mst_b_ready), 32'b0001);
    cyc();
    mst_b_valid = '0;
    #2;
    chk("mm_err", 32'(err), 32'd1);
    chk("mm_valid", 32'(slv_b_valid), 32'd1);
    chk("mm_id", 32'(slv_b_id), 32'h3);
    chk("mm_pop_en", 32'(pop_en), 32'd1);
    chk("mm_pop_id", 32'(pop_axi_id), 32'd3);
    cyc();
    #2;
    chk("mm_err_clr", 32'(err), 32'd0);
    cyc();
    chk("mm_err_once", 32'(err_cnt - e0), 32'd1);

    // Not occupied: ID 7 with nothing in flight
    set_tbl(7, 2'd1, 1'b0);
    e0 = err_cnt;
    send(1, 4'h7, 2'b00);
    exp_q.push_back({4'h7, 2'b00});
    cyc();
    mst_b_valid = '0;
    #2;
    chk("nocc_err", 32'(err), 32'd1);
    chk("nocc_id", 32'(slv_b_id), 32'h7);
    cyc();
    #2;
    chk("nocc_err_clr", 32'(err), 32'd0);
    cyc();
    chk("nocc_err_once", 32'(err_cnt - e0), 32'd1);

    // Reset while a response is buffered
    set_tbl(1, 2'd2, 1'b1);
    slv_b_ready = 1'b0;
    send(2, 4'h1, 2'b00);
    cyc();
    mst_b_valid = '0;
    #2;
    chk("rmid_valid_before", 32'(slv_b_valid), 32'd1);
    p0 = pops;
    rst_ni = 1'b0;
    slv_b_ready = 1'b1;
    #1;
    chk("rmid_valid", 32'(slv_b_valid), 32'd0);
    chk("rmid_pop_en", 32'(pop_en), 32'd0);
    cyc();
    cyc();
    rst_ni = 1'b1;
    set_tbl(6, 2'd0, 1'b1);
    for (int i = 0; i < 4; i++) send(i, 4'hE, 2'b01);
    exp_q.push_back({4'hE, 2'b01});
    #2;
    chk("rmid_grant0", 32'(mst_b_ready), 32'b0001);
    chk("rmid_no_pop", 32'(pops - p0), 32'd0);
    cyc();
    mst_b_valid = '0;
    cyc();
    cyc();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_demux_b_resp.md
# axi_demux_b_resp

B-channel return path for the crossbar slave-side demux: collects write responses from NoMstPorts master-side B channels, picks one per cycle round-robin, and presents it on the single slave-port B channel through a one-entry output register. On each completed slave-port handshake it pops the write-ID tracking array. Before acceptance it checks the response's ID against that array (lookup) and flags responses that arrive from an unexpected master port or for an ID with nothing in flight.

## Interface
Parameters:
- NoMstPorts, 4, number of master-side B inputs (≥2)
- IdWidth, 4, AXI ID width on slave port
- AxiLookBits, 3, ID LSBs used to index the tracking array (≤ IdWidth)
- select_t, logic [idx_width(NoMstPorts)-1:0], master-port select type

Ports (one clock `clk_i`; reset `rst_ni` is asynchronous, active-low):
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- mst_b_valid_i  in  NoMstPorts  per-port B valid
- mst_b_ready_o  out  NoMstPorts  per-port B ready
- mst_b_id_i  in  NoMstPorts×IdWidth  per-port B ID
- mst_b_resp_i  in  NoMstPorts×2  per-port BRESP
- slv_b_valid_o  out  1  slave-port B valid
- slv_b_ready_i  in  1  slave-port B ready
- slv_b_id_o  out  IdWidth  slave-port B ID
- slv_b_resp_o  out  2  slave-port BRESP
- lookup_axi_id_o  out  AxiLookBits  ID to check in tracking array
- lookup_sel_i  in  select_t  port recorded for that ID
- lookup_sel_occupied_i  in  1  ID has transactions in flight
- pop_en_o  out  1  pop one in-flight entry
- pop_axi_id_o  out  AxiLookBits  ID to pop
- err_o  out  1  one-cycle pulse: unexpected response accepted

## Operation
- Output register: `valid_q`, `id_q`, `resp_q`, `src_q`. `load = ~valid_q | slv_b_ready_i`.
- Arbitration: round-robin pointer `rr_q` (select_t). Winner = first i with `mst_b_valid_i[i]`, searching rr_q+1, rr_q+2, … wrapping mod NoMstPorts, rr_q last.
- `mst_b_ready_o[winner] = load`, all other readies 0. Ready never depends on a non-winning valid.
- Accept (any valid & load): capture the winner's id/resp, set src_q=winner, valid_q=1, rr_q=winner. If load and no valid: valid_q=0 (only after slave handshake). rr_q is unchanged when nothing is accepted.
- Lookup: `lookup_axi_id_o = mst_b_id_i[winner][AxiLookBits-1:0]`, combinational; when nothing is valid it drives 0.
- Error: at accept, `err_o` is registered to 1 for one cycle if `~lookup_sel_occupied_i` or `lookup_sel_i != winner`. An erroneous response is still forwarded; it is never dropped.
- Pop: `pop_en_o = valid_q & slv_b_ready_i`; `pop_axi_id_o = id_q[AxiLookBits-1:0]`. Exactly one pop per slave handshake.

## Timing
- Reset values: valid_q=0, rr_q=NoMstPorts-1 (so port 0 wins first), err_o=0. Consequently slv_b_valid_o=0, pop_en_o=0, and all mst_b_ready_o=0 until the first cycle after reset release (load=1).
- Latency: one cycle from master handshake to slv_b_valid_o.
- Throughput: one response per cycle when slv_b_ready_i is held high. A pop and an accept in the same cycle are legal.
- Back-pressure: when valid_q=1 and slv_b_ready_i=0, no master ready is asserted. Slave outputs hold stable (AXI valid/ready rules).
- Wrap-around: the pointer wraps NoMstPorts-1→0. A non-power-of-two NoMstPorts must skip the unused codes.
- Reset asserted mid-transfer: the buffered response is discarded, no pop is issued, and the pointer returns to its reset value.

## Structure
- `idx_width` comes from `axi_math_pkg`. `select_t` and the BRESP typedef (`axi_pkg::resp_t`, with OKAY/EXOKAY/SLVERR/DECERR) belong in the shared package.
- Sub-module `axi_rr_arbiter`: parameter NoMstPorts; inputs valid vector and advance; outputs grant index and any_valid; holds rr_q. It is reusable for the R path.

## Test plan
- Single response: port 2 sends ID 4'h5, BRESP 0, and the lookup returns occupied=1, sel=2. Required: slv_b valid 1 cycle later with ID 5, then pop_en_o=1 with pop_axi_id_o=5 on the handshake, and err_o=0.
- Fairness: all 4 ports valid continuously with slv_b_ready_i=1. Required grant order 0,1,2,3,0,…, one per cycle, and 4 pops per 4 cycles.
- Back-pressure: slv_b_ready_i=0 for 5 cycles with ports 1 and 3 valid. Required: mst_b_ready_o=0 throughout and slv outputs stable. When ready rises, port 1 goes first, then port 3.
- Mismatch: port 0 returns ID 3, but lookup_sel_i=1. Required: err_o pulses once, the response is still forwarded, and ID 3 is popped.
- Not occupied: ID 7 returns with lookup_sel_occupied_i=0. Required: err_o=1 for one cycle.
- Reset mid-transfer: rst_ni is asserted while valid_q=1. Required: slv_b_valid_o=0 immediately, no pop_en_o, and the next grant after release goes to port 0.
